mult_div_ctrl: RTL and testbench
================================

// Module: mult_div_ctrl
// PURPOSE
//  Iterative multiply/divide sequencer with HI/LO registers for the multicycle MIPS core.
//  - Accepts MULT/DIV requests from control_unit and runs a shift-add or restoring-divide loop.
//  - Drives the HI/LO sources of the register-write mux; also serves mthi/mtlo writes.
// PARAMETERS
//  DATA_W   32   operand/result width; iteration count = DATA_W
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high; clears state, HI, LO and flags
//  start      in   1       request pulse, sampled only when accepting (IDLE or DONE)
//  op_sel     in   2       [0]: 0=MULT 1=DIV; [1]: unsigned (only with UNSIGNED_OPS_EN)
//  src_a      in   DATA_W  multiplicand / dividend (Reg_A), latched at accept
//  src_b      in   DATA_W  multiplier / divisor (Reg_B), latched at accept
//  hi_wr      in   1       mthi: HI <= wdata (IDLE/DONE only)
//  lo_wr      in   1       mtlo: LO <= wdata (IDLE/DONE only)
//  wdata      in   DATA_W  mthi/mtlo data
//  busy       out  1       1 in RUN/FIXUP; control_unit stalls mfhi/mflo/new ops
//  done       out  1       one-cycle pulse in DONE
//  div_zero   out  1       set on DIV with src_b==0; held until next accepted start or reset
//  hi_out     out  DATA_W  HI register (remainder / product upper half)
//  lo_out     out  DATA_W  LO register (quotient / product lower half)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high.
//    Reset: state=IDLE, busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0.
//  - FSM IDLE -> RUN -> FIXUP -> DONE -> IDLE. start accepted in IDLE and DONE (back-to-back ok).
//  - Accept (cycle 0 edge):
//    - latch magnitudes |src_a|, |src_b|, result signs, op; counter=DATA_W.
//    - DIV with src_b==0: go directly to DONE; div_zero=1; HI/LO unchanged.
//  - RUN (cycles 1..DATA_W): one bit per cycle; counter decrements; exit when counter hits 0.
//    - MULT: 2*DATA_W product accumulator, add-and-shift right.
//    - DIV: restoring divide; partial remainder DATA_W+1 bits.
//  - FIXUP (cycle DATA_W+1): conditional two's-complement negation.
//    - product: negated if sign_a^sign_b.
//    - quotient: negated if sign_a^sign_b; remainder takes sign of dividend.
//  - DONE (cycle DATA_W+2): HI/LO written at entry, done=1, busy=0.
//    Latency: DATA_W+2 cycles after accept = 34 for DATA_W=32.
//  - Arithmetic: quotient truncates toward zero; all results mod 2^DATA_W.
//    - MULT: {HI,LO} = full 2*DATA_W product.
//    - DIV: LO=quotient, HI=remainder. INT_MIN / -1 -> LO=INT_MIN, HI=0, no flag.
//  - Boundary conditions:
//    - start while busy: ignored; no queueing.
//    - src_a/src_b changes after accept: no effect.
//    - hi_wr/lo_wr while busy: dropped.
//    - start and hi_wr/lo_wr in same accepting cycle: start wins, write dropped.
//    - hi_wr and lo_wr together: both written.
//    - reset in any state: IDLE next cycle; in-flight result discarded.
// CONFIGURATION
//  UNSIGNED_OPS_EN defined: op_sel[1]=1 selects MULTU/DIVU.
//    - operands treated as unsigned; FIXUP negation skipped; same latency.
//  UNSIGNED_OPS_EN undefined: op_sel[1] ignored; all ops signed.
// STRUCTURE
//  - Package mult_div_pkg:
//    - FSM state encoding (IDLE/RUN/FIXUP/DONE).
//    - op_sel bit positions and OP_MULT/OP_DIV constants.
//    - counter width CNT_W = $clog2(DATA_W+1).
//  - Sub-module mult_div_step (combinational): one MULT add-shift or DIV trial-subtract
//    step on the accumulator. FSM, counter, sign logic and HI/LO stay in mult_div_ctrl.
// TESTING
//  1. MULT 7 * -3 -> done at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy=1 cycles 1..33.
//  2. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at cycle 34;
//     DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  3. DIV 5 / 0 -> done and div_zero=1 at cycle 1; HI/LO keep prior values;
//     next accepted start clears div_zero.
//  4. Reset at cycle 10 of MULT -> busy=0, HI=LO=0 next cycle.
//     Second start at cycle 5 of an op -> ignored; first result intact.
//  5. hi_wr=1, wdata=0x1234 in IDLE -> HI=0x1234. Same with start=1 -> HI not written.
//     lo_wr during RUN -> LO unchanged.
//  6. op_sel=2'b10, 0xFFFFFFFF * 2:
//     with UNSIGNED_OPS_EN -> HI=0x00000001, LO=0xFFFFFFFE;
//     without -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// UNSIGNED_OPS_EN (optional macro) enables MULTU/DIVU via op_sel[1].
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIXUP,
    ST_DONE
  } state_t;

  localparam int unsigned OP_DIV_BIT = 0;
  localparam int unsigned OP_UNS_BIT = 1;
  localparam logic        OP_MULT    = 1'b0;
  localparam logic        OP_DIV     = 1'b1;

  localparam int unsigned DATA_W_DEF = 32;

  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DATA_W_DEF);

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the sequencer: MULT add-and-shift-right or DIV restoring
// trial subtract on the {acc_hi, acc_lo} accumulator. Purely combinational.
module mult_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] step_hi,
  output logic [DATA_W-1:0] step_lo
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic            ge;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[DATA_W-1]};
    ge      = (shifted >= {1'b0, opnd});
    if (is_div) begin
      // Partial remainder stays below the divisor, so the W-bit difference is exact.
      step_hi = ge ? (shifted[DATA_W-1:0] - opnd) : shifted[DATA_W-1:0];
      step_lo = {acc_lo[DATA_W-2:0], ge};
    end else begin
      step_hi = sum[DATA_W:1];
      step_lo = {sum[0], acc_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative MULT/DIV sequencer with HI/LO registers and mthi/mtlo write port.
// Optional macro UNSIGNED_OPS_EN: op_sel[1]=1 selects MULTU/DIVU.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op_sel,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_wr,
  input  logic              lo_wr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int unsigned CW = cnt_width(DATA_W);

  state_t state, state_nx;

  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opnd;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [DATA_W-1:0]   hi_q, lo_q, res_hi, res_lo;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [2*DATA_W-1:0] prod;
  logic                is_div, neg_res, neg_rem, div_zero_q;
  logic                accepting, accept, op_div, op_uns, sign_a, sign_b, zero_div;

  assign accepting = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = accepting && start;
  assign op_div    = (op_sel[OP_DIV_BIT] == OP_DIV);
`ifdef UNSIGNED_OPS_EN
  assign op_uns    = op_sel[OP_UNS_BIT];
`else
  assign op_uns    = op_sel[OP_UNS_BIT] & 1'b0;
`endif
  assign sign_a    = !op_uns && src_a[DATA_W-1];
  assign sign_b    = !op_uns && src_b[DATA_W-1];
  assign mag_a     = sign_a ? -src_a : src_a;
  assign mag_b     = sign_b ? -src_b : src_b;
  assign zero_div  = op_div && (src_b == '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = zero_div ? ST_DONE : ST_RUN;
      ST_RUN:   if (cnt == CW'(1)) state_nx = ST_FIXUP;
      ST_FIXUP: state_nx = ST_DONE;
      ST_DONE:  state_nx = accept ? (zero_div ? ST_DONE : ST_RUN) : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  mult_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .is_div  (is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .opnd    (opnd),
    .step_hi (step_hi),
    .step_lo (step_lo)
  );

  assign prod = {acc_hi, acc_lo};

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div) begin
      res_lo = neg_res ? -acc_lo : acc_lo;
      res_hi = neg_rem ? -acc_hi : acc_hi;
    end else begin
      {res_hi, res_lo} = neg_res ? -prod : prod;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      // Multiplier shifts out of acc_lo; dividend shifts out of acc_lo.
      div_zero_q <= zero_div;
      cnt        <= CW'(DATA_W);
      acc_hi     <= '0;
      is_div     <= op_div;
      neg_res    <= sign_a ^ sign_b;
      neg_rem    <= sign_a;
      acc_lo     <= op_div ? mag_a : mag_b;
      opnd       <= op_div ? mag_b : mag_a;
    end else if (accepting) begin
      if (hi_wr) hi_q <= wdata;
      if (lo_wr) lo_q <= wdata;
    end else if (state == ST_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt - 1'b1;
    end else if (state == ST_FIXUP) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
  end

  assign busy     = (state == ST_RUN) || (state == ST_FIXUP);
  assign done     = (state == ST_DONE);
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed self-checking bench for mult_div_ctrl (DATA_W=32).
module tb_mult_div_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_wr, lo_wr;
  logic [1:0]   op_sel;
  logic [W-1:0] src_a, src_b, wdata;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mult_div_ctrl #(
    .DATA_W (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_sel   (op_sel),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_wr    (hi_wr),
    .lo_wr    (lo_wr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Accept an op and advance to cycle 34 (DONE).
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_sel = op;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (33) tick();
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    hi_wr  = 1'b0;
    lo_wr  = 1'b0;
    op_sel = 2'b00;
    src_a  = '0;
    src_b  = '0;
    wdata  = '0;
    tick();
    tick();
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_dz", W'(div_zero), 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    reset = 1'b0;
    tick();

    // MULT 7 * -3 with latency and busy window
    op_sel = 2'b00; src_a = 32'd7; src_b = 32'hFFFF_FFFD; start = 1'b1;
    tick();
    start = 1'b0;
    check("m1_busy_c1", W'(busy), 1);
    check("m1_done_c1", W'(done), 0);
    repeat (32) tick();
    check("m1_busy_c33", W'(busy), 1);
    check("m1_done_c33", W'(done), 0);
    tick();
    check("m1_done_c34", W'(done), 1);
    check("m1_busy_c34", W'(busy), 0);
    check("m1_hi", hi_out, 32'hFFFF_FFFF);
    check("m1_lo", lo_out, 32'hFFFF_FFEB);
    tick();
    check("m1_done_c35", W'(done), 0);

    // Signed divides
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2);
    check("d1_done", W'(done), 1);
    check("d1_lo", lo_out, 32'hFFFF_FFFD);
    check("d1_hi", hi_out, 32'hFFFF_FFFF);
    run_op(2'b01, 32'd100, 32'd7);
    check("d2_lo", lo_out, 32'd14);
    check("d2_hi", hi_out, 32'd2);
    run_op(2'b01, 32'hFFFF_FF9C, 32'd7);
    check("d3_lo", lo_out, 32'hFFFF_FFF2);
    check("d3_hi", hi_out, 32'hFFFF_FFFE);
    run_op(2'b01, 32'd100, 32'hFFFF_FFF9);
    check("d4_lo", lo_out, 32'hFFFF_FFF2);
    check("d4_hi", hi_out, 32'd2);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    check("d5_lo", lo_out, 32'h8000_0000);
    check("d5_hi", hi_out, 32'h0);
    check("d5_dz", W'(div_zero), 0);

    // Divide by zero accepted back-to-back from DONE
    op_sel = 2'b01; src_a = 32'd5; src_b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("dz_done_c1", W'(done), 1);
    check("dz_flag", W'(div_zero), 1);
    check("dz_busy", W'(busy), 0);
    check("dz_hi_keep", hi_out, 32'h0);
    check("dz_lo_keep", lo_out, 32'h8000_0000);
    run_op(2'b00, 32'd3, 32'd4);
    check("dz_cleared", W'(div_zero), 0);
    check("m2_hi", hi_out, 32'h0);
    check("m2_lo", lo_out, 32'd12);

    // Reset at cycle 10 of a MULT
    op_sel = 2'b00; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("rs_busy", W'(busy), 0);
    check("rs_done", W'(done), 0);
    check("rs_hi", hi_out, 32'h0);
    check("rs_lo", lo_out, 32'h0);
    reset = 1'b0;

    // Start during RUN ignored; operand changes after accept ignored
    op_sel = 2'b00; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op_sel = 2'b01; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ig_busy_c6", W'(busy), 1);
    repeat (28) tick();
    check("ig_done", W'(done), 1);
    check("ig_hi", hi_out, 32'h0);
    check("ig_lo", lo_out, 32'd300);
    tick();

    // mthi / mtlo behaviour
    hi_wr = 1'b1; wdata = 32'h1234;
    tick();
    hi_wr = 1'b0;
    check("mthi_hi", hi_out, 32'h1234);
    check("mthi_lo", lo_out, 32'd300);
    hi_wr = 1'b1; wdata = 32'h5678;
    op_sel = 2'b00; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    tick();
    hi_wr = 1'b0; start = 1'b0;
    check("mthi_start_drop", hi_out, 32'h1234);
    lo_wr = 1'b1; wdata = 32'hABCD;
    tick();
    lo_wr = 1'b0;
    check("mtlo_busy_drop", lo_out, 32'd300);
    repeat (32) tick();
    check("m3_hi", hi_out, 32'h0);
    check("m3_lo", lo_out, 32'd6);
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hCAFE;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    check("mtboth_hi", hi_out, 32'hCAFE);
    check("mtboth_lo", lo_out, 32'hCAFE);

    // Unsigned-select op_sel=2'b10
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2);
    check("u_done", W'(done), 1);
`ifdef UNSIGNED_OPS_EN
    check("u_hi", hi_out, 32'h0000_0001);
`else
    check("u_hi", hi_out, 32'hFFFF_FFFF);
`endif
    check("u_lo", lo_out, 32'hFFFF_FFFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
